// File: rtl/ebus_dev_resp.sv
// ebus_dev_resp: EBUS device responder handling CONO/CONI/DATAO/DATAI/PISERVE.
// Define EBUS_PI_EN to enable PI request generation and PISERVE acknowledge.
module ebus_dev_resp #(
    parameter logic [0:6]  DEVNUM = 7'o100,
    parameter logic [0:35] VECTOR = 36'o0
) (
    input  logic         eboxClk,
    input  logic         eboxResetN,
    input  logic [0:6]   ebusCS,
    input  logic [0:2]   ebusFunc,
    input  logic         ebusDemand,
    input  logic [0:35]  ebusDataIn,
    output logic         ebusAck,
    output logic         ebusDriving,
    output logic [0:35]  ebusDataOut,
    input  logic [18:29] devStatus,
    input  logic [0:35]  devDataIn,
    input  logic         devIntReq,
    output logic [0:35]  devDataOut,
    output logic         devDataoStb,
    output logic         devDataiStb,
    output logic [30:35] ctlReg,
    output logic [1:7]   piReq
);
    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;
    localparam logic [0:2] F_CONO = 3'd0, F_CONI = 3'd1, F_DATAO = 3'd2, F_DATAI = 3'd3, F_PISERVE = 3'd6;
    state_t state_q;
    logic armed_q;
    logic pi_ok;
    logic [30:35] coni_ctl;
    logic hit;
`ifdef EBUS_PI_EN
    assign pi_ok = (ctlReg[33:35] != 3'd0) && |piReq;
    assign coni_ctl = ctlReg;
    always_ff @(posedge eboxClk or negedge eboxResetN)
        if (!eboxResetN) piReq <= '0;
        else for (int n = 1; n <= 7; n++) piReq[n] <= devIntReq && (ctlReg[33:35] == 3'(n));
`else
    logic unused_pi;
    assign unused_pi = devIntReq;
    assign pi_ok = 1'b0;
    assign coni_ctl = {ctlReg[30:32], 3'b000};
    assign piReq = '0;
`endif
    // armed_q blocks a demand already high when IDLE was reached via reset
    assign hit = state_q == IDLE && armed_q && ebusDemand && ebusCS == DEVNUM &&
                 (ebusFunc != F_PISERVE || pi_ok);
    always_ff @(posedge eboxClk or negedge eboxResetN)
        if (!eboxResetN) begin
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            ebusAck     <= 1'b0;
            ebusDriving <= 1'b0;
            ebusDataOut <= '0;
            devDataOut  <= '0;
            devDataoStb <= 1'b0;
            devDataiStb <= 1'b0;
            ctlReg      <= '0;
        end else begin
            armed_q     <= (armed_q && !hit) || !ebusDemand;
            devDataoStb <= 1'b0;
            devDataiStb <= 1'b0;
            case (state_q)
                IDLE: if (hit) begin
                    state_q <= ACK;
                    ebusAck <= 1'b1;
                    case (ebusFunc)
                        F_CONO: ctlReg <= ebusDataIn[30:35];
                        F_CONI: begin
                            ebusDriving <= 1'b1;
                            ebusDataOut <= {18'b0, devStatus, coni_ctl};
                        end
                        F_DATAO: begin
                            devDataOut  <= ebusDataIn;
                            devDataoStb <= 1'b1;
                        end
                        F_DATAI: begin
                            ebusDriving <= 1'b1;
                            ebusDataOut <= devDataIn;
                            devDataiStb <= 1'b1;
                        end
                        F_PISERVE: begin
                            ebusDriving <= 1'b1;
                            ebusDataOut <= VECTOR;
                        end
                        default: ;
                    endcase
                end
                ACK: state_q <= HOLD;
                HOLD: if (!ebusDemand) begin
                    state_q     <= IDLE;
                    ebusAck     <= 1'b0;
                    ebusDriving <= 1'b0;
                    ebusDataOut <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
endmodule
